bram_port_arbiter: RTL and testbench

Round-robin arbiter and init sequencer that shares one port of a 2K x 9 dual-port block RAM (8 data + 1 parity bit per word) among NREQ requesters. After reset it can optionally zero-fill the RAM and then grant one access per cycle. Each read returns data tagged to the requester that issued it. It sits between client logic and the RAM primitive's A or B port; the other RAM port is untouched.

---
 rtl/bram_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 38 +++
 rtl/bram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_arb_pkg : shared constants and types for the BRAM port arbiter      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package bram_arb_pkg;

  localparam int RAM_DEPTH  = 2048;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 9;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick  : combinational round-robin picker, first request at/after ptr  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_next_ptr,
  output logic             o_any
);

  int w_dist;

  // Requester i sits (i - ptr) mod NREQ places behind the pointer; smallest distance wins.
  always_comb begin
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    o_any      = 1'b0;
    w_dist     = 0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NREQ - int'(i_ptr));
        if (!o_any && i_req[i] && (w_dist == k)) begin
          o_any      = 1'b1;
          o_gnt[i]   = 1'b1;
          o_next_ptr = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_port_arbiter : round-robin sharing of one BRAM port + zero-fill     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                NREQ           = 4,
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter int                DATA_W         = DATA_W_DEF,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          WE,
  input  logic [NREQ*ADDR_W-1:0]   ADDR,
  input  logic [NREQ*DATA_W-1:0]   DI,
  output logic [NREQ-1:0]          GNT,
  output logic [NREQ-1:0]          RVALID,
  output logic [DATA_W-1:0]        DO,
  output logic                     BUSY,
  output logic                     RAM_EN,
  output logic                     RAM_WE,
  output logic                     RAM_SSR,
  output logic [ADDR_W-1:0]        RAM_ADDR,
  output logic [DATA_W-1:0]        RAM_DI,
  input  logic [DATA_W-1:0]        RAM_DO
);

  localparam int                c_PTR_W     = ptr_width(NREQ);
  localparam state_t            c_RESET_ST  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_clr_cnt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   w_ptr_nxt;
  logic [NREQ-1:0]      w_req_run;
  logic [NREQ-1:0]      w_gnt;
  logic [NREQ-1:0]      r_tag1;
  logic [NREQ-1:0]      r_tag2;
  logic                 w_any;
  logic                 w_run;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_di;
  logic                 r_ram_en;
  logic                 r_ram_we;
  logic [ADDR_W-1:0]    r_ram_addr;
  logic [DATA_W-1:0]    r_ram_di;

  // Gating with RST keeps GNT low while reset is held even when the FSM rests in RUN.
  assign w_run     = (r_state == ST_RUN) && !RST;
  assign w_req_run = REQ & {NREQ{w_run}};

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_PTR_W)
  ) u_pick (
    .i_req      (w_req_run),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_ptr_nxt),
    .o_any      (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_di   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = ADDR[i*ADDR_W +: ADDR_W];
        w_sel_di   = DI[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_we = |(w_gnt & WE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= c_RESET_ST;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == c_LAST_ADDR) w_state_nxt = ST_RUN;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_clr_cnt  <= '0;
      r_ptr      <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_di   <= '0;
    end else begin
      r_tag2 <= r_tag1;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt  <= r_clr_cnt + 1'b1;
        r_ram_en   <= 1'b1;
        r_ram_we   <= 1'b1;
        r_ram_addr <= r_clr_cnt;
        r_ram_di   <= CLEAR_VAL;
        r_tag1     <= '0;
      end else begin
        r_ram_en <= w_any;
        r_ram_we <= w_sel_we;
        r_tag1   <= w_gnt & ~WE;
        if (w_any) begin
          r_ram_addr <= w_sel_addr;
          r_ram_di   <= w_sel_di;
          r_ptr      <= w_ptr_nxt;
        end
      end
    end
  end

  assign GNT      = w_gnt;
  assign RVALID   = r_tag2;
  assign DO       = RAM_DO;
  assign BUSY     = (r_state == ST_CLEAR);
  assign RAM_EN   = r_ram_en;
  assign RAM_WE   = r_ram_we;
  assign RAM_SSR  = 1'b0;
  assign RAM_ADDR = r_ram_addr;
  assign RAM_DI   = r_ram_di;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bram_port_arbiter : self-checking bench with a WRITE_FIRST RAM model  |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_bram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ, WE;
  logic [43:0] ADDR;
  logic [35:0] DI;
  logic [3:0]  GNT, RVALID;
  logic [8:0]  DO, RAM_DI, RAM_DO;
  logic        BUSY, RAM_EN, RAM_WE, RAM_SSR;
  logic [10:0] RAM_ADDR;

  logic [3:0]  req0;
  logic [3:0]  we0   = 4'b0000;
  logic [43:0] addr0 = '0;
  logic [35:0] di0   = '0;
  logic [3:0]  gnt0, rvalid0;
  logic [8:0]  do0, ram_di0;
  logic [8:0]  ram_do0 = 9'h055;
  logic        busy0, ram_en0, ram_we0, ram_ssr0;
  logic [10:0] ram_addr0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  bram_port_arbiter #(
    .NREQ(4), .ADDR_W(11), .DATA_W(9), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(9'h000)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .DI(DI),
    .GNT(GNT), .RVALID(RVALID), .DO(DO), .BUSY(BUSY),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  bram_port_arbiter #(
    .NREQ(4), .ADDR_W(11), .DATA_W(9), .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(9'h000)
  ) dut0 (
    .CLK(CLK), .RST(RST), .REQ(req0), .WE(we0), .ADDR(addr0), .DI(di0),
    .GNT(gnt0), .RVALID(rvalid0), .DO(do0), .BUSY(busy0),
    .RAM_EN(ram_en0), .RAM_WE(ram_we0), .RAM_SSR(ram_ssr0),
    .RAM_ADDR(ram_addr0), .RAM_DI(ram_di0), .RAM_DO(ram_do0)
  );

  // WRITE_FIRST block RAM behaviour
  logic [8:0] mem [0:2047];
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        mem[RAM_ADDR] <= RAM_DI;
        RAM_DO        <= RAM_DI;
      end else begin
        RAM_DO <= mem[RAM_ADDR];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic w, input logic [10:0] a, input logic [8:0] d);
    WE[i]          = w;
    ADDR[i*11 +: 11] = a;
    DI[i*9 +: 9]     = d;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] gnt;
    logic [3:0] rv;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [8:0] d;
  } rd_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Second instance: no clear, immediate grant after release
  initial begin
    req0 = 4'b0001;
    @(negedge RST);
    @(negedge CLK);
    check("nc_busy", {31'd0, busy0}, 32'd0);
    check("nc_first_gnt", {28'd0, gnt0}, 32'h1);
    @(posedge CLK); #1;
    req0 = 4'b0000;
    @(negedge CLK);
    check("nc_rvalid_early", {28'd0, rvalid0}, 32'h0);
    @(negedge CLK);
    check("nc_rvalid", {28'd0, rvalid0}, 32'h1);
    check("nc_do", {23'd0, do0}, 32'h055);
  end

  initial begin
    vec_t tbl [10];
    int   busy_cnt, wr_ok, nxt_addr, gnt_busy;
    int   ptr, j, max_wait, t;
    bit   pend [4];
    bit   pwe [4];
    int   paddr [4], pdi [4], start [4];
    int   mmem [16];
    rd_t  rq [$];
    logic [3:0] exp_g, exp_rv;
    logic [8:0] exp_d;

    RST = 1'b1; REQ = '0; WE = '0; ADDR = '0; DI = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt",     {28'd0, GNT}, 32'h0);
    check("rst_rvalid",  {28'd0, RVALID}, 32'h0);
    check("rst_busy",    {31'd0, BUSY}, 32'h1);
    check("rst_ram_en",  {31'd0, RAM_EN}, 32'h0);
    check("rst_ram_we",  {31'd0, RAM_WE}, 32'h0);
    check("rst_ram_addr",{21'd0, RAM_ADDR}, 32'h0);
    check("rst_ram_di",  {23'd0, RAM_DI}, 32'h0);
    check("rst_ram_ssr", {31'd0, RAM_SSR}, 32'h0);
    check("rst_nc_busy", {31'd0, busy0}, 32'h0);
    check("rst_nc_gnt",  {28'd0, gnt0}, 32'h0);

    // All four request reads of address 0 from before release onward
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 11'h000, 9'h000);
    REQ = 4'b1111;
    @(posedge CLK); #1;
    RST = 1'b0;

    busy_cnt = 0; wr_ok = 0; nxt_addr = 0; gnt_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (RAM_EN === 1'b1) begin
        if (RAM_WE === 1'b1 && RAM_ADDR == 11'(nxt_addr) && RAM_DI === 9'h000) wr_ok++;
        nxt_addr++;
      end
      if (BUSY !== 1'b1) break;
      busy_cnt++;
      if (GNT !== 4'b0000) gnt_busy++;
      @(posedge CLK); #1;
    end
    check("clear_busy_cycles", busy_cnt, 2048);
    check("clear_writes_ok", wr_ok, 2048);
    check("clear_writes_total", nxt_addr, 2048);
    check("clear_gnt_seen", gnt_busy, 0);

    // Continuous reads from all four
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge CLK);
      check("cont_gnt", {28'd0, GNT}, 32'(1 << (k % 4)));
      check("cont_rvalid", {28'd0, RVALID}, (k >= 2) ? 32'(1 << ((k - 2) % 4)) : 32'h0);
      if (k >= 2) check("cont_do", {23'd0, DO}, 32'h0);
      @(posedge CLK); #1;
    end

    // Pattern table; PTR is back to 0 here
    tbl[0] = '{4'b1010, 4'b0000, 4'b0010, 4'b0100};
    tbl[1] = '{4'b1010, 4'b0000, 4'b1000, 4'b1000};
    tbl[2] = '{4'b1010, 4'b0000, 4'b0010, 4'b0010};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
    tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0010};
    tbl[5] = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    tbl[6] = '{4'b1100, 4'b1100, 4'b0100, 4'b0001};
    tbl[7] = '{4'b1100, 4'b1100, 4'b1000, 4'b0010};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 11'h100, 9'h0AA);
    for (int r = 0; r < 10; r++) begin
      REQ = tbl[r].req;
      WE  = tbl[r].we;
      @(negedge CLK);
      check($sformatf("tbl%0d_gnt", r), {28'd0, GNT}, {28'd0, tbl[r].gnt});
      check($sformatf("tbl%0d_rvalid", r), {28'd0, RVALID}, {28'd0, tbl[r].rv});
      @(posedge CLK); #1;
    end

    // Write by 2 then read-after-write by 0
    set_lane(2, 1'b1, 11'h3FF, 9'h1A5);
    set_lane(0, 1'b0, 11'h3FF, 9'h000);
    REQ = 4'b0100;
    @(negedge CLK);
    check("raw_wr_gnt", {28'd0, GNT}, 32'h4);
    @(posedge CLK); #1;
    REQ = 4'b0001;
    @(negedge CLK);
    check("raw_rd_gnt", {28'd0, GNT}, 32'h1);
    check("raw_ram_cmd", {10'd0, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI}, {10'd0, 1'b1, 1'b1, 11'h3FF, 9'h1A5});
    @(posedge CLK); #1;
    REQ = 4'b0000;
    @(negedge CLK);
    check("raw_rvalid_t1", {28'd0, RVALID}, 32'h0);
    @(negedge CLK);
    check("raw_rvalid_t2", {28'd0, RVALID}, 32'h1);
    check("raw_do", {23'd0, DO}, 32'h1A5);
    @(posedge CLK); #1;

    // Randomised traffic against a request-level model (PTR now 1)
    ptr = 1; max_wait = 0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; pwe[i] = 0; paddr[i] = 0; pdi[i] = 0; start[i] = 0; end
    for (int a = 0; a < 16; a++) mmem[a] = 0;
    for (t = 0; t < 420; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (t < 400 && !pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom_range(0, 1));
          paddr[i] = int'($urandom_range(0, 15));
          pdi[i]   = int'($urandom_range(0, 511));
          start[i] = t;
        end
        REQ[i] = pend[i];
        set_lane(i, pwe[i], 11'(paddr[i]), 9'(pdi[i]));
      end
      @(negedge CLK);
      j = -1;
      for (int k = 0; k < 4; k++) if (j < 0 && pend[(ptr + k) % 4]) j = (ptr + k) % 4;
      exp_g = (j < 0) ? 4'b0000 : 4'(1 << j);
      check("rnd_gnt", {28'd0, GNT}, {28'd0, exp_g});
      exp_rv = 4'b0000; exp_d = 9'h000;
      if (rq.size() > 0 && rq[0].due == t) begin
        exp_rv = rq[0].oh; exp_d = rq[0].d;
        void'(rq.pop_front());
      end
      check("rnd_rvalid", {28'd0, RVALID}, {28'd0, exp_rv});
      if (exp_rv != 4'b0000) check("rnd_do", {23'd0, DO}, {23'd0, exp_d});
      for (int i = 0; i < 4; i++)
        if (GNT[i] === 1'b1 && pend[i] && (t - start[i] + 1) > max_wait) max_wait = t - start[i] + 1;
      if (j >= 0) begin
        ptr = (j + 1) % 4;
        pend[j] = 1'b0;
        if (pwe[j]) mmem[paddr[j]] = pdi[j];
        else rq.push_back('{t + 2, 4'(1 << j), 9'(mmem[paddr[j]])});
      end
      @(posedge CLK); #1;
    end
    check("rnd_drained", rq.size(), 0);
    check("rnd_fairness", (max_wait >= 1 && max_wait <= 4) ? 1 : 0, 1);

    // Reset while a read is in flight
    REQ = 4'b0010;
    set_lane(1, 1'b0, 11'h005, 9'h000);
    @(negedge CLK);
    check("mid_gnt", {28'd0, GNT}, 32'h2);
    @(posedge CLK); #1;
    REQ = 4'b0000;
    check("mid_inflight_en", {31'd0, RAM_EN}, 32'h1);
    RST = 1'b1;
    #1;
    check("mid_ram_en_async", {31'd0, RAM_EN}, 32'h0);
    check("mid_busy", {31'd0, BUSY}, 32'h1);
    @(negedge CLK);
    check("mid_rvalid_a", {28'd0, RVALID}, 32'h0);
    @(negedge CLK);
    check("mid_rvalid_b", {28'd0, RVALID}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("mid_r0_en", {31'd0, RAM_EN}, 32'h0);
    check("mid_r0_rvalid", {28'd0, RVALID}, 32'h0);
    @(negedge CLK);
    check("mid_r1_cmd", {20'd0, RAM_EN, RAM_WE, RAM_ADDR}, {20'd0, 1'b1, 1'b1, 11'h000});
    check("mid_r1_rvalid", {28'd0, RVALID}, 32'h0);
    @(negedge CLK);
    check("mid_r2_addr", {21'd0, RAM_ADDR}, 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
